// File: rtl/uart_loader.sv
// Byte-stream packet loader: parses HEADER/ADDR/LEN/payload frames from the UART receiver and
// issues little-endian 32-bit words on a valid/ready write port. Define UART_LOADER_CHECKSUM_EN
// to require a trailing 8-bit checksum byte.
module uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1_700_000,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_rdy,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
`ifdef UART_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [23:0]   asm_q, asm_d;
  logic [15:0]   words_q, words_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_d, done_d, err_d;
  logic [31:0]   wr_addr_d, wr_data_d;
  logic [1:0]    err_code_d;
  logic          hs;

  assign hs   = wr_en && wr_ready;
  assign busy = (state_q != StIdle) || wr_en;

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == StIdle) begin
      sum_d = '0;
    end else if (data_rdy && (state_q inside {StAddr, StLen, StData})) begin
      sum_d = sum_q + data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    asm_d      = asm_q;
    words_d    = words_q;
    tmo_d      = '0;
    wr_en_d    = wr_en;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    done_d     = 1'b0;
    err_d      = err;
    err_code_d = err_code;

    if (hs) wr_en_d = 1'b0;
    if (state_q != StIdle && !data_rdy && !hs) tmo_d = tmo_q + TW'(1);

    unique case (state_q)
      StIdle: begin
        if (data_rdy && data_in == HEADER) begin
          err_d      = 1'b0;
          err_code_d = 2'd0;
          byte_cnt_d = '0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (data_rdy) begin
          addr_d     = {data_in, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StLen;
        end
      end
      StLen: begin
        if (data_rdy) begin
          words_d    = {data_in, words_q[15:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = '0;
            if ({data_in, words_q[15:8]} == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              done_d  = 1'b1;
              state_d = StIdle;
`endif
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (data_rdy) begin
          asm_d      = {data_in, asm_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // The output slot is free if empty or being handshaken this very cycle.
            if (!wr_en || wr_ready) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {data_in, asm_q};
              addr_d    = addr_q + 32'd4;
              words_d   = words_q - 16'd1;
              if (words_q == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                state_d = StCsum;
`else
                state_d = StDrain;
`endif
              end
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
              state_d    = StIdle;
            end
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      StCsum: begin
        if (data_rdy) begin
          if (data_in == sum_q) begin
            if (!wr_en || hs) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StDrain;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
            state_d    = StIdle;
          end
        end
      end
`endif
      StDrain: begin
        if (!wr_en || hs) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !data_rdy && !hs && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      err_d      = 1'b1;
      err_code_d = 2'd1;
      wr_en_d    = 1'b0;
      tmo_d      = '0;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      asm_q      <= '0;
      words_q    <= '0;
      tmo_q      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
      tmo_q      <= tmo_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      done       <= done_d;
      err        <= err_d;
      err_code   <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: scoreboard of expected writes, per-scenario tasks.
`timescale 1ns/1ps
module tb_uart_loader;

  localparam int unsigned TMO = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_rdy = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [63:0] exp_q [$];
  logic [31:0] pay [$];

  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr, prev_data;

  uart_loader #(.TIMEOUT_CYCLES(TMO), .HEADER(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_rdy (data_rdy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // Write monitor: pops the scoreboard on each handshake, checks held outputs while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        total++;
        if (wr_en !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
          bad++;
          $display("FAIL hold: got en=%b %h@%h want 1 %h@%h", wr_en, wr_data, wr_addr,
                   prev_data, prev_addr);
        end
      end
      if (wr_en && wr_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write: unexpected %h@%h", wr_data, wr_addr);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            bad++;
            $display("FAIL write: got %h@%h want %h@%h", wr_data, wr_addr, e[31:0], e[63:32]);
          end
        end
      end
      prev_hold = wr_en && !wr_ready;
      prev_addr = wr_addr;
      prev_data = wr_data;
      if (done) done_cnt++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    data_in  = b;
    data_rdy = 1'b1;
    @(posedge clk); #1;
    data_rdy = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Sends a packet for the words in pay; only the first n_push writes are expected to happen.
  task automatic send_packet(input logic [31:0] addr, input int gap, input int n_push,
                             input bit send_csum, input bit bad_csum);
    logic [7:0]  sum;
    logic [15:0] n;
    logic [7:0]  b;
    sum = 8'h00;
    n   = 16'(pay.size());
    send_byte(8'hA5, gap);
    for (int i = 0; i < 4; i++) begin
      b = addr[8*i +: 8];
      sum += b;
      send_byte(b, gap);
    end
    for (int i = 0; i < 2; i++) begin
      b = n[8*i +: 8];
      sum += b;
      send_byte(b, gap);
    end
    for (int w = 0; w < pay.size(); w++) begin
      for (int i = 0; i < 4; i++) begin
        b = pay[w][8*i +: 8];
        sum += b;
        if (i == 3 && w < n_push) exp_q.push_back({addr + 32'(4 * w), pay[w]});
        send_byte(b, gap);
      end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    if (send_csum) send_byte(bad_csum ? sum + 8'd1 : sum, gap);
`else
    if (send_csum && bad_csum) $display("note: checksum disabled in this build");
`endif
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == budget) begin
      total++;
      bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, want 0", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 7;
    if (wr_en !== 1'b0)      begin bad++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
    if (done !== 1'b0)       begin bad++; $display("FAIL reset done: got %b want 0", done); end
    if (err !== 1'b0)        begin bad++; $display("FAIL reset err: got %b want 0", err); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    if (err_code !== 2'd0)   begin bad++; $display("FAIL reset err_code: got %0d want 0", err_code); end
    if (wr_addr !== 32'd0)   begin bad++; $display("FAIL reset wr_addr: got %h want 0", wr_addr); end
    if (wr_data !== 32'd0)   begin bad++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
  endtask

  task automatic check_end(input string name, input int done_want, input int d0,
                           input logic err_want, input logic [1:0] code_want);
    total += 3;
    if (done_cnt - d0 !== done_want) begin
      bad++; $display("FAIL %s done: got %0d pulses want %0d", name, done_cnt - d0, done_want);
    end
    if (err !== err_want || (err_want && err_code !== code_want)) begin
      bad++; $display("FAIL %s err: got %b/%0d want %b/%0d", name, err, err_code, err_want, code_want);
    end
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL %s writes: %0d expected writes missing, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    wr_ready = 1'b1;
    pay = '{32'h44332211, 32'h88776655};
    send_packet(32'h0000_1000, 2, 2, 1'b1, 1'b0);
    wait_idle(200, "basic");
    check_end("basic", 1, d0, 1'b0, 2'd0);
  endtask

  task automatic test_stall();
    int d0;
    d0 = done_cnt;
    wr_ready = 1'b0;
    pay = '{32'h44332211, 32'h88776655};
    fork
      send_packet(32'h0000_1000, 20, 2, 1'b1, 1'b0);
      begin
        int k;
        for (k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (wr_en) break;
        end
        total++;
        if (k == 1000) begin bad++; $display("FAIL stall: wr_en got 0 want 1"); end
        repeat (50) @(posedge clk);
        #1 wr_ready = 1'b1;
      end
    join
    wait_idle(200, "stall");
    check_end("stall", 1, d0, 1'b0, 2'd0);
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    wr_ready = 1'b0;
    pay = '{32'hA1B2C3D4, 32'h01020304};
    send_packet(32'h0000_3000, 2, 1, 1'b0, 1'b0);
    total += 3;
    if (err !== 1'b1 || err_code !== 2'd2) begin
      bad++; $display("FAIL overrun code: got %b/%0d want 1/2", err, err_code);
    end
    if (wr_en !== 1'b1 || wr_data !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL overrun pending: got %b %h want 1 a1b2c3d4", wr_en, wr_data);
    end
    if (busy !== 1'b1) begin bad++; $display("FAIL overrun busy: got %b want 1", busy); end
    @(posedge clk); #1 wr_ready = 1'b1;
    wait_idle(50, "overrun");
    check_end("overrun", 0, d0, 1'b1, 2'd2);
  endtask

  task automatic test_timeout_len_zero();
    int d0, k;
    wr_ready = 1'b1;
    send_byte(8'hA5, 2);
    send_byte(8'h00, 2);
    send_byte(8'h10, 2);
    send_byte(8'h00, 2);
    for (k = 0; k < TMO + 50; k++) begin
      @(negedge clk);
      if (err) break;
    end
    total += 3;
    if (k == TMO + 50 || k < TMO - 10) begin
      bad++; $display("FAIL timeout delay: got %0d cycles want about %0d", k, TMO);
    end
    if (err_code !== 2'd1) begin bad++; $display("FAIL timeout code: got %0d want 1", err_code); end
    @(negedge clk);
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout busy: got %b want 0", busy); end
    d0 = done_cnt;
    send_byte(8'hA5, 2);
    total++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      bad++; $display("FAIL header clear: got %b/%0d want 0/0", err, err_code);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h00, 2);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h00, 2);
`endif
    wait_idle(50, "len0");
    check_end("len0", 1, d0, 1'b0, 2'd0);
  endtask

`ifdef UART_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    d0 = done_cnt;
    wr_ready = 1'b1;
    pay = '{32'h44332211, 32'h88776655};
    send_packet(32'h0000_1000, 2, 2, 1'b1, 1'b1);
    wait_idle(50, "csum");
    check_end("csum", 0, d0, 1'b1, 2'd3);
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] bytes [$];
    int d0;
    wr_ready = 1'b0;
    bytes = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (bytes[i]) send_byte(bytes[i], 2);
    @(negedge clk);
    total++;
    if (wr_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL pre-reset: got en=%b busy=%b want 1 1", wr_en, busy);
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    total++;
    if ({wr_en, busy, done, err, err_code, wr_addr, wr_data} !== 70'd0) begin
      bad++; $display("FAIL async reset: got en=%b busy=%b addr=%h data=%h want all 0",
                      wr_en, busy, wr_addr, wr_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    d0 = done_cnt;
    pay = '{32'hCAFEF00D, 32'h12345678, 32'h0BADBEEF};
    send_packet(32'h0000_2000, 2, 3, 1'b1, 1'b0);
    wait_idle(50, "post-reset");
    check_end("post-reset", 1, d0, 1'b0, 2'd0);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    wr_ready = 1'b1;
    pay = '{32'hDEADBEEF, 32'hA5A5A5A5};
    send_packet(32'hFFFF_FFFC, 1, 2, 1'b1, 1'b0);
    pay = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    send_packet(32'h0000_0040, 1, 3, 1'b1, 1'b0);
    wait_idle(50, "b2b");
    check_end("b2b", 2, d0, 1'b0, 2'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    #2 rst_n = 1'b1;
    test_basic();
    test_stall();
    test_overrun();
    test_timeout_len_zero();
`ifdef UART_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
